// File: rtl/rsa_pkg.sv
// Shared constants and UART state encoding for the RSA datapath.
package rsa_pkg;
  localparam int WORD_W               = 32;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;
endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one 8N1 byte; ready is high in IDLE and on the last stop-bit cycle,
// so a start on that cycle chains the next byte with no idle gap.
module uart_byte_tx
  import rsa_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_r, state_next_s;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             tx_r, tx_next_s;
  logic             bit_end_s, ready_s, load_s;

  assign bit_end_s = (baud_cnt_r == CNT_LAST);
  assign ready_s   = (state_r == UART_IDLE) || ((state_r == UART_STOP) && bit_end_s);
  assign load_s    = start && ready_s;
  assign ready     = ready_s;
  assign tx        = tx_r;

  // State and serial line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= UART_IDLE;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      tx_r    <= tx_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      UART_IDLE:  if (start) state_next_s = UART_START; else state_next_s = UART_IDLE;
      UART_START: if (bit_end_s) state_next_s = UART_DATA; else state_next_s = UART_START;
      UART_DATA:  if (bit_end_s && (bit_idx_r == 3'd7)) state_next_s = UART_STOP;
                  else state_next_s = UART_DATA;
      UART_STOP:  if (bit_end_s) state_next_s = start ? UART_START : UART_IDLE;
                  else state_next_s = UART_STOP;
      default:    state_next_s = UART_IDLE;
    endcase
  end

  // Line level for the state being entered; in DATA a bit boundary exposes the next bit
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      UART_IDLE:  tx_next_s = 1'b1;
      UART_START: tx_next_s = 1'b0;
      UART_DATA:  if ((state_r == UART_DATA) && bit_end_s) tx_next_s = shift_r[1];
                  else tx_next_s = shift_r[0];
      UART_STOP:  tx_next_s = 1'b1;
      default:    tx_next_s = 1'b1;
    endcase
  end

  // Baud counter, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else if (load_s) begin
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= byte_in;
    end else if (state_r != UART_IDLE) begin
      baud_cnt_r <= bit_end_s ? '0 : baud_cnt_r + 1'b1;
      if ((state_r == UART_DATA) && bit_end_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
        shift_r   <= shift_r >> 1;
      end
    end
  end
endmodule

// File: rtl/rsa_word_uart_tx.sv
// Sends a BYTES-wide word as back-to-back 8N1 frames, most-significant byte first.
module rsa_word_uart_tx
  import rsa_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int BYTES        = WORD_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*BYTES-1:0] data_in,
  input  logic               load,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               overrun
);
  localparam int W    = 8 * BYTES;
  localparam int BI_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);

  logic            load_q_r, busy_r, done_r, overrun_r;
  logic [BI_W-1:0] byte_idx_r;
  logic [W-1:0]    word_r;
  logic            req_s, accept_s, ready_s, last_s, more_s, finish_s, start_s;
  logic [7:0]      byte_s;

  assign req_s    = load && !load_q_r;
  assign accept_s = req_s && !busy_r;
  assign last_s   = (byte_idx_r == LAST_BYTE);
  assign more_s   = busy_r && ready_s && !last_s;
  assign finish_s = busy_r && ready_s && last_s;
  assign start_s  = accept_s || more_s;
  // word_r holds the not-yet-sent bytes left-aligned
  assign byte_s   = accept_s ? data_in[W-1 -: 8] : word_r[W-1 -: 8];

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst),
    .start   (start_s),
    .byte_in (byte_s),
    .ready   (ready_s),
    .tx      (tx)
  );

  // Request edge detection, byte sequencing and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
      byte_idx_r <= '0;
      word_r     <= '0;
    end else begin
      load_q_r  <= load;
      done_r    <= finish_s;
      overrun_r <= req_s && busy_r;
      if (accept_s) begin
        busy_r     <= 1'b1;
        byte_idx_r <= '0;
        word_r     <= data_in << 4'd8;
      end else if (more_s) begin
        byte_idx_r <= byte_idx_r + 1'b1;
        word_r     <= word_r << 4'd8;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign overrun = overrun_r;
endmodule

// File: tb/tb_rsa_word_uart_tx.sv
// Randomised/directed bench: cycle-level line model plus a UART receiver feeding a word scoreboard.
module tb_rsa_word_uart_tx;
  localparam int CPB   = 4;
  localparam int BYTES = 4;
  localparam int FRAME = 10 * BYTES * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic        tx, busy, done, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  rsa_word_uart_tx #(.CLKS_PER_BIT(CPB), .BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: accepted words, start edge, overrun flag
  int          cyc = 0;
  bit          active = 1'b0;
  int          start_k = 0;
  logic [31:0] cur_word = 32'h0;
  bit          load_prev = 1'b0;
  bit          ov_exp = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active = 1'b0; load_prev = 1'b0; ov_exp = 1'b0;
      exp_q.delete();
    end else begin
      bit req, busy_m;
      cyc++;
      req       = load && !load_prev;
      load_prev = load;
      busy_m    = active && ((cyc - start_k) <= FRAME);
      ov_exp    = req && busy_m;
      if (req && !busy_m) begin
        active = 1'b1; start_k = cyc; cur_word = data_in;
        exp_q.push_back(data_in);
      end
    end
  end

  function automatic logic line_at(int t, logic [31:0] w);
    int b, pos;
    logic [31:0] sh;
    if (t < 0 || t >= FRAME) return 1'b1;
    b   = t / (10 * CPB);
    pos = (t % (10 * CPB)) / CPB;
    sh  = w >> (8 * (BYTES - 1 - b));
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return sh[pos-1];
  endfunction

  // Per-cycle output monitor
  always @(negedge clk) begin
    int t;
    t = cyc - start_k;
    chk("tx",      tx,      active ? line_at(t, cur_word) : 1'b1);
    chk("busy",    busy,    active && (t < FRAME));
    chk("done",    done,    active && (t == FRAME));
    chk("overrun", overrun, rst && ov_exp);
  end

  // Independent UART receiver feeding the word scoreboard
  bit          rx_act = 1'b0;
  int          rx_cnt = 0, rx_n = 0;
  logic [7:0]  rx_byte;
  logic [31:0] rx_word;

  always @(negedge clk) begin
    if (!rst) begin
      rx_act = 1'b0; rx_n = 0;
    end else begin
      if (!rx_act && tx == 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
      if (rx_act) begin
        if (rx_cnt % CPB == CPB / 2) begin
          int j;
          j = rx_cnt / CPB;
          if (j >= 1 && j <= 8) rx_byte[j-1] = tx;
          if (j == 9) begin
            chk("stop_bit", tx, 1'b1);
            rx_word = {rx_word[23:0], rx_byte};
            rx_act  = 1'b0;
            rx_n++;
            if (rx_n == BYTES) begin
              rx_n = 0;
              if (exp_q.size() == 0) chk("word_unexpected", rx_word, 32'hxxxxxxxx);
              else chk("word", rx_word, exp_q.pop_front());
            end
          end
        end
        rx_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] w);
    data_in = w; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; data_in = 32'h0;
    step(3);
    rst = 1'b1;
    step(5);
    // basic word, one-cycle load
    send(32'habccef01);
    step(200);
    // load held high sends a single word
    data_in = 32'h12345678; load = 1'b1;
    step(400);
    load = 1'b0;
    step(10);
    // overrun at cycle 50 with changed data_in
    send(32'hc0ffee11);
    step(48);
    send(32'h00000000);
    step(150);
    // reset mid-byte at cycle 70
    send(32'h5a5aa5a5);
    step(68);
    rst = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    step(3);
    rst = 1'b1;
    step(2);
    send(32'h3c3cc3c3);
    step(200);
    // new request in the done cycle
    send(32'h9876fedc);
    step(159);
    send(32'h00ff00ff);
    step(200);
    // randomised words, gaps and pulse widths
    for (int i = 0; i < 12; i++) begin
      step($urandom_range(0, 180));
      data_in = $urandom; load = 1'b1;
      step($urandom_range(1, 5));
      load = 1'b0;
    end
    step(400);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("rx_partial", rx_n, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
